// File: rtl/cont_pkg.sv
// Shared constants and helpers for the loadable up/down counter family.
//   MODE_WRAP / MODE_SAT : values for the SAT_MODE parameter
//   DIR_DOWN / DIR_UP    : encodings of the Up direction input
//   clamp_load()         : limits a load value to the terminal count
package cont_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Load values above the terminal count are pulled down to it, so the
    // register can never hold a value outside 0..max.
    function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                               input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/cont_term_det.sv
// Terminal-count detector for one counter stage (purely combinational).
//   q_i       : current registered count
//   up_i      : direction, DIR_UP or DIR_DOWN
//   ce_i      : count enable of this stage
//   at_term_o : count sits at the terminal for the current direction
//   rc_o      : ripple carry/borrow, at_term_o qualified by ce_i; drives
//               the CE of the next stage in a cascade
module cont_term_det
    import cont_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter logic [31:0] MAX_VAL = 32'd15
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             up_i,
    input  logic             ce_i,
    output logic             at_term_o,
    output logic             rc_o
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    // Up-counting terminates at MAX_VAL, down-counting at zero.
    assign at_term_o = (up_i == DIR_UP) ? (q_i == MAX_W) : (q_i == '0);
    // Deliberately not gated by a load: RC only reflects CE, Up and Q.
    assign rc_o      = ce_i & at_term_o;

endmodule

// File: rtl/cont_ld_updown.sv
// Parametrised up/down counter with synchronous load, programmable
// terminal count, wrap or saturate behaviour and a registered event pulse.
//   Ck  : clock, rising edge
//   Clr : asynchronous active-high clear of Q and Ovf
//   CE  : count enable
//   L   : synchronous load (beats CE)
//   Up  : direction, 1 = up, 0 = down
//   I   : load value, clamped to MAX_VAL
//   Q   : current count, always within 0..MAX_VAL
//   RC  : combinational ripple carry/borrow for cascading
//   Ovf : one-cycle pulse after an enabled edge taken at the terminal
module cont_ld_updown
    import cont_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter logic [31:0] MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int          SAT_MODE = MODE_WRAP
) (
    input  logic             Ck,
    input  logic             Clr,
    input  logic             CE,
    input  logic             L,
    input  logic             Up,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Q,
    output logic             RC,
    output logic             Ovf
);

    // Elaboration-time parameter checks.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("cont_ld_updown: WIDTH must be in 2..32");
    end
    if (MAX_VAL == 32'd0 || 64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("cont_ld_updown: MAX_VAL must be in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             at_term;

    // Increment/decrement at WIDTH+1 bits; the extra bit is never needed
    // because the terminal check intercepts both ends of the range.
    logic [WIDTH:0] inc_w, dec_w;
    logic           unused_carry;

    assign inc_w        = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_w        = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};
    assign unused_carry = inc_w[WIDTH] ^ dec_w[WIDTH];

    cont_term_det #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_term_det (
        .q_i       (q_q),
        .up_i      (Up),
        .ce_i      (CE),
        .at_term_o (at_term),
        .rc_o      (RC)
    );

    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        if (L) begin
            q_d = WIDTH'(clamp_load(32'(I), MAX_VAL));
        end else if (CE) begin
            if (at_term) begin
                ovf_d = 1'b1;
                if (SAT_MODE == MODE_SAT) begin
                    q_d = q_q;
                end else begin
                    q_d = (Up == DIR_UP) ? '0 : MAX_W;
                end
            end else if (Up == DIR_UP) begin
                q_d = inc_w[WIDTH-1:0];
            end else begin
                q_d = dec_w[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge Ck or posedge Clr) begin
        if (Clr) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign Q   = q_q;
    assign Ovf = ovf_q;

endmodule

// File: tb/tb_cont_ld_updown.sv
// Directed bench for cont_ld_updown: a wrap instance and a saturate instance
// share one stimulus stream; a two-stage decade cascade is checked at the end.
module tb_cont_ld_updown;

    logic       Ck;
    logic       Clr, CE, L, Up;
    logic [3:0] I;
    logic [3:0] q_w, q_s;
    logic       rc_w, rc_s, ovf_w, ovf_s;

    logic       c_clr, c_ce;
    logic [3:0] c0_q, c1_q;
    logic       c0_rc, c1_rc, c0_ovf, c1_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    cont_ld_updown #(.WIDTH(4), .MAX_VAL(32'd9), .SAT_MODE(0)) dut_wrap (
        .Ck(Ck), .Clr(Clr), .CE(CE), .L(L), .Up(Up), .I(I),
        .Q(q_w), .RC(rc_w), .Ovf(ovf_w)
    );

    cont_ld_updown #(.WIDTH(4), .MAX_VAL(32'd9), .SAT_MODE(1)) dut_sat (
        .Ck(Ck), .Clr(Clr), .CE(CE), .L(L), .Up(Up), .I(I),
        .Q(q_s), .RC(rc_s), .Ovf(ovf_s)
    );

    cont_ld_updown #(.WIDTH(4), .MAX_VAL(32'd9), .SAT_MODE(0)) stage0 (
        .Ck(Ck), .Clr(c_clr), .CE(c_ce), .L(1'b0), .Up(1'b1), .I(4'd0),
        .Q(c0_q), .RC(c0_rc), .Ovf(c0_ovf)
    );

    cont_ld_updown #(.WIDTH(4), .MAX_VAL(32'd9), .SAT_MODE(0)) stage1 (
        .Ck(Ck), .Clr(c_clr), .CE(c0_rc), .L(1'b0), .Up(1'b1), .I(4'd0),
        .Q(c1_q), .RC(c1_rc), .Ovf(c1_ovf)
    );

    // Clock
    initial Ck = 1'b0;
    always #5 Ck = ~Ck;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge Ck);
        #1;
    endtask

    task automatic drive(input logic l, input logic ce, input logic up,
                         input logic [3:0] i);
        L  = l;
        CE = ce;
        Up = up;
        I  = i;
    endtask

    initial begin
        Clr = 1'b1; c_clr = 1'b1; c_ce = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 4'd0);
        #3;
        check("reset_q_wrap", 32'(q_w), 0);
        check("reset_ovf_wrap", 32'(ovf_w), 0);
        check("reset_q_sat", 32'(q_s), 0);
        step();
        Clr = 1'b0;

        // Load and clamp
        drive(1'b1, 1'b0, 1'b1, 4'd3);
        step();
        check("load3_q", 32'(q_w), 3);
        check("load3_ovf", 32'(ovf_w), 0);
        drive(1'b1, 1'b0, 1'b1, 4'd12);
        step();
        check("load12_clamp_q", 32'(q_w), 9);
        check("load12_clamp_q_sat", 32'(q_s), 9);
        drive(1'b1, 1'b1, 1'b1, 4'd5);
        #1;
        check("rc_not_gated_by_load", 32'(rc_w), 1);
        step();
        check("load_beats_count", 32'(q_w), 5);
        check("load_beats_count_ovf", 32'(ovf_w), 0);

        // Asynchronous clear mid-cycle with Q=5
        drive(1'b0, 1'b0, 1'b1, 4'd0);
        #3;
        Clr = 1'b1;
        #1;
        check("async_clr_q", 32'(q_w), 0);
        check("async_clr_ovf", 32'(ovf_w), 0);
        #19;
        Clr = 1'b0;
        step();
        check("after_clr_hold_q", 32'(q_w), 0);

        // Up-wrap from 8
        drive(1'b1, 1'b0, 1'b1, 4'd8);
        step();
        check("load8_q", 32'(q_w), 8);
        drive(1'b0, 1'b1, 1'b1, 4'd0);
        #1;
        check("up_rc_at8", 32'(rc_w), 0);
        step();
        check("up_q9", 32'(q_w), 9);
        check("up_q9_ovf", 32'(ovf_w), 0);
        check("up_q9_rc", 32'(rc_w), 1);
        step();
        check("up_wrap_q0", 32'(q_w), 0);
        check("up_wrap_ovf", 32'(ovf_w), 1);
        check("up_wrap_rc", 32'(rc_w), 0);
        check("up_sat_q9", 32'(q_s), 9);
        check("up_sat_ovf", 32'(ovf_s), 1);
        check("up_sat_rc", 32'(rc_s), 1);
        step();
        check("up_wrap_q1", 32'(q_w), 1);
        check("up_wrap_ovf_drop", 32'(ovf_w), 0);
        check("up_sat_q9_again", 32'(q_s), 9);
        check("up_sat_ovf_again", 32'(ovf_s), 1);

        // Down-wrap and saturate from 1
        drive(1'b1, 1'b0, 1'b0, 4'd1);
        step();
        check("load1_q_wrap", 32'(q_w), 1);
        check("load1_q_sat", 32'(q_s), 1);
        check("load1_ovf_sat", 32'(ovf_s), 0);
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        step();
        check("dn_q0_wrap", 32'(q_w), 0);
        check("dn_q0_ovf", 32'(ovf_w), 0);
        check("dn_q0_rc", 32'(rc_w), 1);
        check("dn_q0_sat", 32'(q_s), 0);
        step();
        check("dn_wrap_q9", 32'(q_w), 9);
        check("dn_wrap_ovf", 32'(ovf_w), 1);
        check("dn_wrap_rc", 32'(rc_w), 0);
        check("dn_sat_q0", 32'(q_s), 0);
        check("dn_sat_ovf", 32'(ovf_s), 1);
        check("dn_sat_rc", 32'(rc_s), 1);
        step();
        check("dn_wrap_q8", 32'(q_w), 8);
        check("dn_wrap_ovf_drop", 32'(ovf_w), 0);
        check("dn_sat_q0_2", 32'(q_s), 0);
        check("dn_sat_ovf_2", 32'(ovf_s), 1);
        CE = 1'b0;
        step();
        check("hold_clears_ovf_sat", 32'(ovf_s), 0);
        check("hold_q_sat", 32'(q_s), 0);
        check("hold_rc_sat", 32'(rc_s), 0);

        // CE gating at Q=4 while counting up
        drive(1'b1, 1'b0, 1'b1, 4'd3);
        step();
        drive(1'b0, 1'b1, 1'b1, 4'd0);
        step();
        check("gate_q4", 32'(q_w), 4);
        CE = 1'b0;
        #1;
        check("gate_rc_low", 32'(rc_w), 0);
        step();
        check("gate_hold_q4", 32'(q_w), 4);
        check("gate_hold_ovf", 32'(ovf_w), 0);
        CE = 1'b1;
        step();
        check("gate_resume_q5", 32'(q_w), 5);

        // Two-stage decade cascade: 25 edges from zero
        c_clr = 1'b0;
        c_ce  = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            step();
            check($sformatf("cascade_edge%0d", n), 32'({c1_q, c0_q}),
                  32'(((n / 10) << 4) | (n % 10)));
        end
        check("cascade_final", 32'({c1_q, c0_q}), 32'h25);
        c_ce = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
